i_ram_boot_ctrl: RTL
====================

Name: i_ram_boot_ctrl

Overview:
Boot/load controller for the instruction RAM.
- Receives a byte stream (from the UART receiver) on a valid/ready handshake.
- Assembles bytes into 16-bit words and writes them sequentially into the instruction RAM write port.
- Holds the CPU in reset while loading, then gates the CPU fetch path onto the RAM read port once released.

Parameters:
- addr_width, 12, instruction RAM address width (depth = 1<<addr_width words)
- data_width, 16, RAM word width; fixed at 16 (two bytes per word)
- BOOT_ON_RESET, 1, 1 = enter load mode after reset; 0 = come out of reset running
- TIMEOUT, 24'd12_000_000, idle clocks allowed between bytes before abort (24-bit counter)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- boot_req  in  1  single-cycle pulse: start a load (ignored unless in RUN)
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid & rx_ready
- cpu_addr  in  addr_width  CPU fetch address
- cpu_rd_en  in  1  CPU fetch enable
- cpu_rst_n  out  1  active-low CPU reset
- ram_w_addr  out  addr_width  RAM write address
- ram_din  out  data_width  RAM write data
- ram_w_en  out  1  RAM write enable
- ram_r_addr  out  addr_width  RAM read address
- ram_r_en  out  1  RAM read enable
- load_done  out  1  one-cycle pulse on successful load completion
- load_err  out  1  sticky error flag; cleared on next boot_req

Behaviour:
Clocking and reset
- Reset is asynchronous and active-low (rst_n); everything else is synchronous to posedge clk.
- All outputs are registered except ram_r_addr and ram_r_en.
- Reset values:
  - rx_ready=0, ram_w_en=0, ram_w_addr=0, ram_din=0, load_done=0, load_err=0.
  - cpu_rst_n = !BOOT_ON_RESET.
  - State = CNT_LO if BOOT_ON_RESET, else RUN.

States: RUN, CNT_LO, CNT_HI, DAT_LO, DAT_HI.
- RUN:
  - cpu_rst_n=1, rx_ready=0.
  - ram_r_addr=cpu_addr, ram_r_en=cpu_rd_en.
  - On boot_req: cpu_rst_n<=0, load_err<=0, go to CNT_LO.
- All other states:
  - rx_ready=1, ram_r_en=0, ram_r_addr=cpu_addr (don't care).
- CNT_LO / CNT_HI:
  - Accepted bytes form the 16-bit word count N, low byte first.
  - N=0 → go to RUN with load_done pulse; RAM untouched.
- DAT_LO / DAT_HI:
  - Low byte latched in DAT_LO.
  - Accepting the high byte causes, next cycle: ram_w_en=1 for exactly one cycle, ram_din={hi,lo}, ram_w_addr=word index k.
  - k starts at 0 and increments after each write.
  - k wraps modulo 1<<addr_width; N larger than the depth overwrites from address 0.
- After word N-1 is written: next cycle go to RUN with cpu_rst_n=1 and a load_done pulse.
  - Net effect: cpu_rst_n rises 1 cycle after the final ram_w_en.

Timeout and reset
- An idle counter clears on every accepted byte and on entry to load.
- If it reaches TIMEOUT in any non-RUN state: load_err<=1, go to RUN, release the CPU, no load_done. Partially written words remain.
- boot_req during a load is ignored.
- rst_n mid-load aborts immediately to the reset state; the partial image is not erased.

Optional Feature:
- Macro: I_RAM_BOOT_CHECKSUM_EN.
- Enabled:
  - Add state CHK after the last data byte; expects one byte equal to the 8-bit modulo-256 sum of all 2N data bytes (count bytes excluded).
  - Match → RUN with load_done.
  - Mismatch → load_err<=1, no load_done, and cpu_rst_n stays 0 until the next boot_req (or reset) and a successful load.
  - Timeout in CHK behaves as a normal timeout.
- Disabled: no CHK state and no checksum accumulator; load_err is set only by timeout.

Decomposition:
- Package i_ram_boot_pkg:
  - State enum encoding (3 bits).
  - TIMEOUT default.
  - Byte-order constant (LSB first).
- One natural sub-module: i_ram_boot_timer (loadable idle counter with clear and expire outputs).
- Word assembly and the FSM stay in the top module.

Test Plan:
- BOOT_ON_RESET=1, release rst_n, send 02 00 34 12 CD AB → RAM writes 0x1234@0 and 0xABCD@1; cpu_rst_n rises 1 cycle after the second ram_w_en; load_done pulses once.
- RUN with cpu_rd_en=1, cpu_addr=0x005 → ram_r_en=1 and ram_r_addr=0x005 in the same cycle; during a load ram_r_en=0 regardless of cpu_rd_en.
- Send count 00 00 → no ram_w_en; load_done pulses; cpu released.
- Send 03 00 11 22, then stall longer than TIMEOUT → one write of 0x2211@0; load_err=1; cpu_rst_n=1; no load_done; the next boot_req clears load_err.
- Insert rx_valid gaps and a boot_req mid-load with 01 00 EF BE → gaps cause no duplicate writes; boot_req ignored; 0xBEEF@0.
- CHECKSUM_EN: 01 00 01 02 03 → success; the same load with final byte 04 → load_err=1 and cpu_rst_n held at 0.

Source files
------------

// File: rtl/i_ram_boot_pkg.sv
// Shared definitions for the instruction-RAM boot loader.
// Contents: FSM state encoding (3 bits), default idle timeout, byte order.
// Optional macro I_RAM_BOOT_CHECKSUM_EN adds the StChk state.
package i_ram_boot_pkg;

  typedef enum logic [2:0] {
    StRun   = 3'd0,
    StCntLo = 3'd1,
    StCntHi = 3'd2,
    StDatLo = 3'd3,
    StDatHi = 3'd4
`ifdef I_RAM_BOOT_CHECKSUM_EN
    , StChk = 3'd5
`endif
  } state_e;

  localparam logic [23:0] TimeoutDefault = 24'd12_000_000;

  // Multi-byte fields (word count and data words) arrive least significant byte first.
  localparam bit LsbFirst = 1'b1;

endpackage

// File: rtl/i_ram_boot_if.sv
// Bus bundle between the boot controller and its surroundings.
// master: controller view (byte stream + CPU fetch in, RAM ports + status out).
// slave : environment view (opposite directions).
interface i_ram_boot_if #(
  parameter int unsigned addr_width = 12,
  parameter int unsigned data_width = 16
);
  logic                  boot_req;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [addr_width-1:0] cpu_addr;
  logic                  cpu_rd_en;
  logic                  cpu_rst_n;
  logic [addr_width-1:0] ram_w_addr;
  logic [data_width-1:0] ram_din;
  logic                  ram_w_en;
  logic [addr_width-1:0] ram_r_addr;
  logic                  ram_r_en;
  logic                  load_done;
  logic                  load_err;

  modport master (
    input  boot_req, rx_data, rx_valid, cpu_addr, cpu_rd_en,
    output rx_ready, cpu_rst_n, ram_w_addr, ram_din, ram_w_en, ram_r_addr, ram_r_en,
           load_done, load_err
  );

  modport slave (
    output boot_req, rx_data, rx_valid, cpu_addr, cpu_rd_en,
    input  rx_ready, cpu_rst_n, ram_w_addr, ram_din, ram_w_en, ram_r_addr, ram_r_en,
           load_done, load_err
  );
endinterface

// File: rtl/i_ram_boot_timer.sv
// Idle counter for the boot loader.
// Ports: clk, rst_n (async active-low), i_clr (zero the count), i_run (count while set),
//        o_expired (count has reached TIMEOUT while running).
module i_ram_boot_timer
  import i_ram_boot_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = TimeoutDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expired
);
  logic [23:0] r_cnt;

  // Saturates at TIMEOUT so o_expired stays up until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != TIMEOUT)) begin
      r_cnt <= r_cnt + 24'd1;
    end
  end

  assign o_expired = i_run & (r_cnt == TIMEOUT);
endmodule

// File: rtl/i_ram_boot_ctrl.sv
// Instruction-RAM boot/load controller.
// Receives a byte stream (count N, then 2N data bytes), writes N 16-bit words to the RAM
// write port, holds the CPU in reset while loading and routes CPU fetches to the RAM read
// port while running.
// Ports: clk, rst_n (async active-low), io_bus (i_ram_boot_if.master: boot_req, rx_*, cpu_*,
//        ram_*, load_done, load_err).
// Optional macro I_RAM_BOOT_CHECKSUM_EN: a trailing modulo-256 checksum byte is required.
module i_ram_boot_ctrl
  import i_ram_boot_pkg::*;
#(
  parameter int unsigned addr_width    = 12,
  parameter int unsigned data_width    = 16,
  parameter bit          BOOT_ON_RESET = 1'b1,
  parameter logic [23:0] TIMEOUT       = TimeoutDefault
) (
  input logic            clk,
  input logic            rst_n,
  i_ram_boot_if.master   io_bus
);
  state_e                r_state, w_state_d;
  logic                  r_rx_ready, w_rx_ready_d;
  logic [15:0]           r_n, w_n_d;
  logic [15:0]           r_idx, w_idx_d;
  logic [7:0]            r_lo, w_lo_d;
  logic [addr_width-1:0] r_k, w_k_d;
  logic [addr_width-1:0] r_w_addr, w_w_addr_d;
  logic [data_width-1:0] r_din, w_din_d;
  logic                  r_w_en, w_w_en_d;
  logic                  r_cpu_rst_n, w_cpu_rst_n_d;
  logic                  r_done, w_done_d;
  logic                  r_err, w_err_d;
  // Set on the last data byte: release the CPU one cycle after the final write.
  logic                  r_pend, w_pend_d;
`ifdef I_RAM_BOOT_CHECKSUM_EN
  logic [7:0]            r_sum, w_sum_d;
`endif
  logic                  w_accept, w_expired, w_tmr_clr, w_tmr_run;
  logic [15:0]           w_n_full, w_word;

  assign w_accept  = io_bus.rx_valid & r_rx_ready;
  assign w_tmr_run = (r_state != StRun);
  assign w_tmr_clr = (r_state == StRun) | w_accept;
  assign w_n_full  = LsbFirst ? {io_bus.rx_data, r_n[7:0]} : {r_n[15:8], io_bus.rx_data};
  assign w_word    = LsbFirst ? {io_bus.rx_data, r_lo} : {r_lo, io_bus.rx_data};

  i_ram_boot_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_tmr_clr),
    .i_run     (w_tmr_run),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_d     = r_state;
    w_n_d         = r_n;
    w_idx_d       = r_idx;
    w_lo_d        = r_lo;
    w_k_d         = r_k;
    w_w_addr_d    = r_w_addr;
    w_din_d       = r_din;
    w_w_en_d      = 1'b0;
    w_cpu_rst_n_d = r_cpu_rst_n;
    w_done_d      = 1'b0;
    w_err_d       = r_err;
    w_pend_d      = 1'b0;
`ifdef I_RAM_BOOT_CHECKSUM_EN
    w_sum_d       = r_sum;
`endif
    unique case (r_state)
      StRun: begin
        if (r_pend) begin
          w_cpu_rst_n_d = 1'b1;
          w_done_d      = 1'b1;
        end else if (io_bus.boot_req) begin
          w_cpu_rst_n_d = 1'b0;
          w_err_d       = 1'b0;
          w_k_d         = '0;
          w_idx_d       = '0;
          w_state_d     = StCntLo;
`ifdef I_RAM_BOOT_CHECKSUM_EN
          w_sum_d       = '0;
`endif
        end
      end
      StCntLo: begin
        if (w_accept) begin
          w_n_d     = LsbFirst ? {8'h00, io_bus.rx_data} : {io_bus.rx_data, 8'h00};
          w_state_d = StCntHi;
        end
      end
      StCntHi: begin
        if (w_accept) begin
          w_n_d = w_n_full;
          if (w_n_full == 16'd0) begin
            w_state_d     = StRun;
            w_cpu_rst_n_d = 1'b1;
            w_done_d      = 1'b1;
          end else begin
            w_state_d = StDatLo;
          end
        end
      end
      StDatLo: begin
        if (w_accept) begin
          w_lo_d    = io_bus.rx_data;
          w_state_d = StDatHi;
`ifdef I_RAM_BOOT_CHECKSUM_EN
          w_sum_d   = r_sum + io_bus.rx_data;
`endif
        end
      end
      StDatHi: begin
        if (w_accept) begin
          w_w_en_d   = 1'b1;
          w_din_d    = w_word;
          w_w_addr_d = r_k;
          w_k_d      = r_k + addr_width'(1);
          w_idx_d    = r_idx + 16'd1;
`ifdef I_RAM_BOOT_CHECKSUM_EN
          w_sum_d    = r_sum + io_bus.rx_data;
`endif
          if (r_idx == r_n - 16'd1) begin
`ifdef I_RAM_BOOT_CHECKSUM_EN
            w_state_d = StChk;
`else
            w_state_d = StRun;
            w_pend_d  = 1'b1;
`endif
          end else begin
            w_state_d = StDatLo;
          end
        end
      end
`ifdef I_RAM_BOOT_CHECKSUM_EN
      StChk: begin
        if (w_accept) begin
          w_state_d = StRun;
          if (io_bus.rx_data == r_sum) begin
            w_cpu_rst_n_d = 1'b1;
            w_done_d      = 1'b1;
          end else begin
            // CPU stays in reset until a later load succeeds.
            w_err_d = 1'b1;
          end
        end
      end
`endif
      default: w_state_d = StRun;
    endcase

    // An accepted byte restarts the idle window, so it wins over an expiry in the same cycle.
    if (w_expired && !w_accept) begin
      w_state_d     = StRun;
      w_err_d       = 1'b1;
      w_cpu_rst_n_d = 1'b1;
      w_w_en_d      = 1'b0;
      w_done_d      = 1'b0;
    end

    w_rx_ready_d = (w_state_d != StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= BOOT_ON_RESET ? StCntLo : StRun;
      r_rx_ready  <= 1'b0;
      r_n         <= '0;
      r_idx       <= '0;
      r_lo        <= '0;
      r_k         <= '0;
      r_w_addr    <= '0;
      r_din       <= '0;
      r_w_en      <= 1'b0;
      r_cpu_rst_n <= !BOOT_ON_RESET;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_pend      <= 1'b0;
`ifdef I_RAM_BOOT_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_rx_ready  <= w_rx_ready_d;
      r_n         <= w_n_d;
      r_idx       <= w_idx_d;
      r_lo        <= w_lo_d;
      r_k         <= w_k_d;
      r_w_addr    <= w_w_addr_d;
      r_din       <= w_din_d;
      r_w_en      <= w_w_en_d;
      r_cpu_rst_n <= w_cpu_rst_n_d;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
      r_pend      <= w_pend_d;
`ifdef I_RAM_BOOT_CHECKSUM_EN
      r_sum       <= w_sum_d;
`endif
    end
  end

  assign io_bus.rx_ready   = r_rx_ready;
  assign io_bus.cpu_rst_n  = r_cpu_rst_n;
  assign io_bus.ram_w_addr = r_w_addr;
  assign io_bus.ram_din    = r_din;
  assign io_bus.ram_w_en   = r_w_en;
  assign io_bus.load_done  = r_done;
  assign io_bus.load_err   = r_err;
  // Fetch path is combinational so the CPU sees RAM with no added latency.
  assign io_bus.ram_r_addr = io_bus.cpu_addr;
  assign io_bus.ram_r_en   = (r_state == StRun) & io_bus.cpu_rd_en;
endmodule
